crc_stream_engine: RTL and testbench
====================================

# crc_stream_engine

Parametrised, streaming, word-parallel CRC engine with valid/ready handshakes. It is the next generation of the team's byte-parallel CRC-16 block, with generic polynomial, width, init, reflection and final-XOR settings. It supports back-pressure, per-frame generate and check modes, and automatic CRC append. It sits inline in the data path between a frame source and the link/MAC layer.

## Interface
- CRC_W, 16: CRC width; must be an integer multiple of DATA_W.
- DATA_W, 8: data word width per beat.
- POLY, 16'h8005: generator polynomial, normal (MSB-first) form, implicit x^CRC_W term.
- INIT, 0: CRC register value at the start of every frame.
- XOR_OUT, 0: final XOR applied to the CRC for append and crc_value.
- REFLECT, 0: 1 means reflect every input word and the final CRC, and append least-significant chunk first.
- RESIDUE, 0: expected register value after a check-mode frame that includes its CRC.
- clk, input, 1: clock; all state is updated on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: input beat valid.
- in_data, input, DATA_W: input word.
- in_last, input, 1: last data beat of the frame.
- in_ready, output, 1: engine accepts the beat this cycle.
- check_mode, input, 1: 0 means generate+append, 1 means check; sampled on a frame's first accepted beat.
- out_valid, output, 1: output beat valid (registered).
- out_data, output, DATA_W: output word (registered).
- out_last, output, 1: last beat of the output frame (registered).
- out_ready, input, 1: downstream accepts the beat.
- crc_done, output, 1: one-cycle pulse when the frame CRC is final.
- crc_ok, output, 1: check result, held until the next crc_done.
- crc_value, output, CRC_W: final CRC (after reflect/XOR_OUT), held until the next crc_done.

## Operation
- Accept: beat accepted when in_valid && in_ready. Output register advance: adv = !out_valid || out_ready.
- States:
  - IDLE: no frame open; crc_reg = INIT.
  - DATA: frame open.
  - APPEND: emit NB = CRC_W/DATA_W CRC chunks.
- IDLE/DATA: in_ready = adv. An accepted beat is copied unchanged to the output register and updates crc_reg ← f(crc_reg, in_data) in a single cycle. f is the DATA_W-step unrolled LFSR of POLY. For REFLECT=1, in_data is bit-reversed before entering f.
- IDLE → DATA on an accepted beat with in_last=0. On this beat, latch mode ← check_mode.
- Accepted beat with in_last=1, from IDLE or DATA (single-beat frames are legal):
  - Generate mode: go to APPEND. out_last on this data beat = 0. Latch fin = (REFLECT ? rev(crc_next) : crc_next) ^ XOR_OUT.
  - Check mode: go to IDLE. out_last = 1. crc_ok ← (crc_next == RESIDUE).
  - Both modes: crc_reg ← INIT, crc_value ← fin, and crc_done pulses the next cycle.
- APPEND:
  - in_ready = 0.
  - Each time adv is true, load one chunk of fin into the output register.
  - Chunk order: MSB chunk first for REFLECT=0, LSB chunk first for REFLECT=1.
  - A 0..NB-1 chunk counter wraps to 0 on the last chunk; the last chunk has out_last = 1, then go to IDLE.
- Generate mode: crc_ok ← 1 on crc_done.
- check_mode changes mid-frame are ignored.
- Widths: all CRC arithmetic is modulo-2 over CRC_W bits; no truncation of POLY/INIT/XOR_OUT beyond CRC_W.

## Timing
- Reset values (rst=1 at an edge):
  - state = IDLE, crc_reg = INIT, chunk counter = 0.
  - out_valid = 0, out_data = 0, out_last = 0.
  - crc_done = 0, crc_ok = 0, crc_value = 0.
  - in_ready = 0 while rst is high.
- Reset mid-frame or mid-append discards the frame. No crc_done is produced and the pending output beat is dropped.
- Latency: input beat to out_valid is 1 cycle.
  - Generate mode: the first CRC chunk appears on the cycle after the last data beat, if out_ready was held high.
  - crc_done is exactly 1 cycle after the in_last acceptance.
- Back-pressure: out_valid=1 && out_ready=0 holds out_data/out_last stable and drops in_ready. No beat is lost or duplicated.
- Throughput:
  - Check mode: 1 beat/cycle, with back-to-back frames and no gap.
  - Generate mode: NB bubble cycles on the input per frame.
- in_valid while in_ready=0 has no effect; the source must hold the beat.

## Test plan
- Defaults (CRC-16/BUYPASS), generate mode, "123456789" (0x31..0x39), out_ready=1 → 11 output beats: the data followed by 0xFE, 0xE8, out_last on 0xE8; crc_value = 0xFEE8; crc_done pulse 1 cycle after the '9' is accepted.
- REFLECT=1 (CRC-16/ARC), same data → appended 0x3D then 0xBB; crc_value = 0xBB3D.
- POLY=16'h1021, INIT=16'hFFFF (CCITT-FALSE), same data → crc_value = 0x29B1; appended 0x29, 0xB1.
- Check mode, defaults:
  - "123456789",0xFE,0xE8 → crc_ok=1, no extra beats, out_last on 0xE8.
  - The same frame with bit 0 of '5' flipped → crc_ok=0.
  - The two frames sent back-to-back with no idle cycle → two crc_done pulses 11 cycles apart.
- Random out_ready toggling (~50%) during a generate-mode frame → output stream identical to the out_ready=1 case; out_data stable whenever out_valid && !out_ready.
- Assert rst during the second APPEND chunk → next cycle out_valid=0, crc_done never pulses, state IDLE; a following frame produces the correct CRC (0xFEE8 for "123456789").

Source files
------------

// File: rtl/crc_stream_engine.sv
// crc_stream_engine: streaming word-parallel CRC generator/checker with
// valid/ready handshakes, configurable polynomial/init/reflect/xor-out.
// Ports: clk, rst (sync, active-high); in_valid/in_data/in_last/in_ready
// input stream; check_mode (0 gen+append, 1 check); out_valid/out_data/
// out_last/out_ready output stream; crc_done pulse, crc_ok, crc_value.
module crc_stream_engine #(
  parameter int               CRC_W   = 16,
  parameter int               DATA_W  = 8,
  parameter logic [CRC_W-1:0] POLY    = 16'h8005,
  parameter logic [CRC_W-1:0] INIT    = '0,
  parameter logic [CRC_W-1:0] XOR_OUT = '0,
  parameter bit               REFLECT = 1'b0,
  parameter logic [CRC_W-1:0] RESIDUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              check_mode,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              crc_done,
  output logic              crc_ok,
  output logic [CRC_W-1:0]  crc_value
);

  localparam int NB = CRC_W / DATA_W;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NB - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    APPEND
  } state_t;

  state_t state, state_d;

  logic [CRC_W-1:0]  crc_reg;
  logic [CRC_W-1:0]  crc_next;
  logic [CRC_W-1:0]  fin_next;
  logic [CRC_W-1:0]  wide;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] chunk;
  logic [CW-1:0]     cnt;
  logic              mode;
  logic              cur_mode;
  logic              adv;
  logic              accept;
  logic              chunk_last;
  int                sel;

  function automatic logic [DATA_W-1:0] rev_d(
    input logic [DATA_W-1:0] v
  );
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
    return r;
  endfunction

  function automatic logic [CRC_W-1:0] rev_c(
    input logic [CRC_W-1:0] v
  );
    logic [CRC_W-1:0] r;
    for (int i = 0; i < CRC_W; i++) r[i] = v[CRC_W-1-i];
    return r;
  endfunction

  // DATA_W serial LFSR steps unrolled into one combinational update,
  // data consumed MSB first.
  function automatic logic [CRC_W-1:0] step(
    input logic [CRC_W-1:0]  c,
    input logic [DATA_W-1:0] d
  );
    logic [CRC_W-1:0] r;
    logic             fb;
    r = c;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = r[CRC_W-1] ^ d[i];
      r  = r << 1;
      if (fb) r = r ^ POLY;
    end
    return r;
  endfunction

  always_comb begin
    din      = REFLECT ? rev_d(in_data) : in_data;
    crc_next = step(crc_reg, din);
    fin_next = (REFLECT ? rev_c(crc_next) : crc_next) ^ XOR_OUT;
  end

  // crc_value holds the finished CRC for the whole APPEND phase, so the
  // chunks are sliced straight out of it.
  always_comb begin
    sel        = REFLECT ? int'(cnt) : (NB - 1) - int'(cnt);
    wide       = crc_value >> (sel * DATA_W);
    chunk      = wide[DATA_W-1:0];
    chunk_last = (cnt == LAST_CNT);
  end

  always_comb begin
    state_d  = state;
    in_ready = 1'b0;
    adv      = !out_valid || out_ready;
    // the first beat of a frame takes its mode live, later beats use
    // the latched copy
    cur_mode = (state == IDLE) ? check_mode : mode;
    if (!rst) begin
      unique case (state)
        IDLE,
        DATA:    in_ready = adv;
        APPEND:  in_ready = 1'b0;
        default: in_ready = 1'b0;
      endcase
    end
    accept = in_valid && in_ready;
    if (accept) begin
      if (in_last) state_d = cur_mode ? IDLE : APPEND;
      else         state_d = DATA;
    end else if (state == APPEND && adv && chunk_last) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_reg   <= INIT;
      cnt       <= '0;
      mode      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      crc_done  <= 1'b0;
      crc_ok    <= 1'b0;
      crc_value <= '0;
    end else begin
      crc_done <= 1'b0;
      if (accept) begin
        if (state == IDLE) mode <= check_mode;
        out_valid <= 1'b1;
        out_data  <= in_data;
        out_last  <= in_last && cur_mode;
        if (in_last) begin
          crc_reg   <= INIT;
          crc_value <= fin_next;
          crc_done  <= 1'b1;
          crc_ok    <= cur_mode ? (crc_next == RESIDUE) : 1'b1;
          cnt       <= '0;
        end else begin
          crc_reg <= crc_next;
        end
      end else if (state == APPEND && adv) begin
        out_valid <= 1'b1;
        out_data  <= chunk;
        out_last  <= chunk_last;
        cnt       <= chunk_last ? '0 : cnt + 1'b1;
      end else if (adv) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_crc_stream_engine.sv
// tb_crc_stream_engine: scoreboard bench for crc_stream_engine running
// BUYPASS, ARC and CCITT-FALSE instances in lockstep on one stream.
module tb_crc_stream_engine;

  typedef logic [7:0] bq_t[$];

  typedef struct packed {
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] d2;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic [15:0] v0;
    logic [15:0] v1;
    logic [15:0] v2;
    logic        ok0;
    logic        ok1;
    logic        ok2;
  } done_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       check_mode = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] in_data = 8'h00;

  logic [2:0]  ir, ov, ol, cd, cok;
  logic [7:0]  od [3];
  logic [15:0] cv [3];

  int    n_chk = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    last_acc = -10;
  bit    rand_ready = 1'b0;
  int    done_cyc[$];
  beat_t exp_b[$];
  done_t exp_d[$];

  always #5 clk = ~clk;

  crc_stream_engine u_buy (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(ir[0]), .check_mode(check_mode),
    .out_valid(ov[0]), .out_data(od[0]), .out_last(ol[0]),
    .out_ready(out_ready),
    .crc_done(cd[0]), .crc_ok(cok[0]), .crc_value(cv[0])
  );

  crc_stream_engine #(.REFLECT(1'b1)) u_arc (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(ir[1]), .check_mode(check_mode),
    .out_valid(ov[1]), .out_data(od[1]), .out_last(ol[1]),
    .out_ready(out_ready),
    .crc_done(cd[1]), .crc_ok(cok[1]), .crc_value(cv[1])
  );

  crc_stream_engine #(.POLY(16'h1021), .INIT(16'hFFFF)) u_ccitt (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(ir[2]), .check_mode(check_mode),
    .out_valid(ov[2]), .out_data(od[2]), .out_last(ol[2]),
    .out_ready(out_ready),
    .crc_done(cd[2]), .crc_ok(cok[2]), .crc_value(cv[2])
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // CRC as polynomial long division: (INIT*x^n + M*x^16) mod P.
  function automatic logic [15:0] crc_div(input bq_t msg,
                                          input logic [15:0] poly,
                                          input logic [15:0] init,
                                          input bit refl);
    bit          dv[$];
    int          nb;
    logic [15:0] r;
    foreach (msg[k])
      for (int i = 7; i >= 0; i--)
        dv.push_back(refl ? msg[k][7-i] : msg[k][i]);
    nb = dv.size();
    for (int i = 0; i < 16; i++) dv.push_back(1'b0);
    for (int i = 0; i < 16; i++) dv[i] = dv[i] ^ init[15-i];
    for (int i = 0; i < nb; i++)
      if (dv[i])
        for (int j = 0; j < 16; j++) dv[i+1+j] = dv[i+1+j] ^ poly[15-j];
    for (int j = 0; j < 16; j++) r[15-j] = dv[nb+j];
    return r;
  endfunction

  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  function automatic logic [15:0] raw_of(input int k, input bq_t msg);
    if (k == 1) return crc_div(msg, 16'h8005, 16'h0000, 1'b1);
    if (k == 2) return crc_div(msg, 16'h1021, 16'hFFFF, 1'b0);
    return crc_div(msg, 16'h8005, 16'h0000, 1'b0);
  endfunction

  function automatic logic [15:0] fin_of(input int k, input bq_t msg);
    logic [15:0] r;
    r = raw_of(k, msg);
    return (k == 1) ? rev16(r) : r;
  endfunction

  task automatic issue(input bq_t msg, input bit mode);
    logic [15:0] raw [3];
    logic [15:0] fin [3];
    beat_t       b;
    done_t       d;
    int          n;
    int          t;
    n = msg.size();
    for (int k = 0; k < 3; k++) begin
      raw[k] = raw_of(k, msg);
      fin[k] = fin_of(k, msg);
    end
    for (int i = 0; i < n; i++) begin
      b = '{msg[i], msg[i], msg[i], mode && (i == n - 1)};
      exp_b.push_back(b);
    end
    if (!mode) begin
      b = '{fin[0][15:8], fin[1][7:0], fin[2][15:8], 1'b0};
      exp_b.push_back(b);
      b = '{fin[0][7:0], fin[1][15:8], fin[2][7:0], 1'b1};
      exp_b.push_back(b);
    end
    d.v0  = fin[0];
    d.v1  = fin[1];
    d.v2  = fin[2];
    d.ok0 = mode ? (raw[0] == 16'h0) : 1'b1;
    d.ok1 = mode ? (raw[1] == 16'h0) : 1'b1;
    d.ok2 = mode ? (raw[2] == 16'h0) : 1'b1;
    exp_d.push_back(d);
    for (int i = 0; i < n; i++) begin
      in_valid   = 1'b1;
      in_data    = msg[i];
      in_last    = (i == n - 1);
      check_mode = (i == 0) ? mode : 1'($urandom_range(0, 1));
      t = 0;
      forever begin
        @(negedge clk);
        if (ir[0]) break;
        t++;
        if (t > 200) begin
          n_chk++;
          n_fail++;
          $display("FAIL accept_timeout: beat %0d not taken", i);
          break;
        end
      end
      if (in_last) last_acc = cyc;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    while ((exp_b.size() != 0 || exp_d.size() != 0) && t < 500) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain", 64'(exp_b.size() + exp_d.size()), 64'(0));
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin : monitor
    logic       stalled;
    logic [7:0] pd;
    logic       pl;
    beat_t      b;
    done_t      d;
    stalled = 1'b0;
    pd = 8'h00;
    pl = 1'b0;
    forever begin
      @(negedge clk);
      if (cd[0]) begin
        done_cyc.push_back(cyc);
        chk("done_latency", 64'(cyc), 64'(last_acc + 1));
        if (exp_d.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL done_unexpected: crc_value %h", cv[0]);
        end else begin
          d = exp_d.pop_front();
          chk("done", 64'({cv[0], cv[1], cv[2], cok[0], cok[1], cok[2]}),
              64'(d));
        end
      end
      if (!rst) begin
        chk("lockstep", 64'({ov[1], ov[2], ir[1], ir[2], cd[1], cd[2]}),
            64'({ov[0], ov[0], ir[0], ir[0], cd[0], cd[0]}));
        if (stalled)
          chk("stall_hold", 64'({ov[0], od[0], ol[0]}),
              64'({1'b1, pd, pl}));
        stalled = ov[0] && !out_ready;
        pd = od[0];
        pl = ol[0];
        if (ov[0] && out_ready) begin
          if (exp_b.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL beat_unexpected: data %h", od[0]);
          end else begin
            b = exp_b.pop_front();
            chk("beat", 64'({od[0], od[1], od[2], ol[0], ol[1], ol[2]}),
                64'({b.d0, b.d1, b.d2, b.last, b.last, b.last}));
          end
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin : stim
    bq_t s9;
    bq_t good;
    bq_t bad;
    bq_t m;
    int  n;
    s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
           8'h36, 8'h37, 8'h38, 8'h39};
    good = s9;
    good.push_back(8'hFE);
    good.push_back(8'hE8);
    bad = good;
    bad[4] = 8'h34;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out", 64'({ov[0], od[0], ol[0]}), 64'(0));
    chk("rst_done", 64'({cd[0], cok[0], cv[0]}), 64'(0));
    chk("rst_in_ready", 64'(ir), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    issue(s9, 1'b0);
    drain();
    chk("kat_buypass", 64'(cv[0]), 64'(16'hFEE8));
    chk("kat_arc", 64'(cv[1]), 64'(16'hBB3D));
    chk("kat_ccitt", 64'(cv[2]), 64'(16'h29B1));

    issue(good, 1'b1);
    drain();
    chk("check_ok", 64'(cok[0]), 64'(1));
    issue(bad, 1'b1);
    drain();
    chk("check_bad", 64'(cok[0]), 64'(0));

    done_cyc.delete();
    issue(good, 1'b1);
    issue(bad, 1'b1);
    drain();
    chk("b2b_count", 64'(done_cyc.size()), 64'(2));
    if (done_cyc.size() >= 2)
      chk("b2b_gap", 64'(done_cyc[1] - done_cyc[0]), 64'(11));

    rand_ready = 1'b1;
    issue(s9, 1'b0);
    drain();
    chk("rand_ready_crc", 64'(cv[0]), 64'(16'hFEE8));

    for (int f = 0; f < 14; f++) begin
      m.delete();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) m.push_back(8'($urandom_range(0, 255)));
      rand_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 2) != 0) begin
          m.push_back(fin_of(0, m) >> 8);
          m.push_back(8'(fin_of(0, m[0:n-1])));
        end
        issue(m, 1'b1);
      end else begin
        issue(m, 1'b0);
      end
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    drain();

    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    issue(s9, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    exp_b.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_valid", 64'(ov[0]), 64'(0));
    chk("rst_mid_done", 64'(cd[0]), 64'(0));
    @(negedge clk);
    chk("rst_mid_idle", 64'(ir[0]), 64'(1));
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_no_done", 64'({cd[0], ov[0]}), 64'(0));
    end
    @(posedge clk);
    #1;
    issue(s9, 1'b0);
    drain();
    chk("post_rst_crc", 64'(cv[0]), 64'(16'hFEE8));

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: run did not complete");
    $fatal(1);
  end

endmodule
